// File: rtl/nasti_stream_tx.sv
// Packet transmitter: staging memory filled through a write port, then streamed out as
// ceil(len/BYTES) beats with t_last and residual-byte t_keep/t_strb on the final beat.
module nasti_stream_tx #(
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 64,
  parameter int BUF_SIZE   = 8,
  localparam int BYTES = DATA_WIDTH / 8,
  localparam int AW    = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1,
  localparam int LW    = $clog2(BUF_SIZE * BYTES + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic [LW-1:0]         len,
  input  logic [ID_WIDTH-1:0]   pkt_id,
  input  logic [DEST_WIDTH-1:0] pkt_dest,
  input  logic [USER_WIDTH-1:0] pkt_user,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  t_valid,
  input  logic                  t_ready,
  output logic [DATA_WIDTH-1:0] t_data,
  output logic [BYTES-1:0]      t_strb,
  output logic [BYTES-1:0]      t_keep,
  output logic                  t_last,
  output logic [ID_WIDTH-1:0]   t_id,
  output logic [DEST_WIDTH-1:0] t_dest,
  output logic [USER_WIDTH-1:0] t_user
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [LW-1:0] MAX_LEN = LW'(BUF_SIZE * BYTES);

  state_t                state_r;
  logic [DATA_WIDTH-1:0] mem_r [BUF_SIZE];
  logic [LW-1:0]         len_r;
  logic [AW:0]           nbeats_r;
  logic [AW:0]           beat_r;
  logic [AW:0]           beat_next_s;
  logic [AW:0]           nbeats_s;
  logic [LW:0]           nb_wide_s;
  logic [DATA_WIDTH-1:0] first_word_s;

  // Final-beat byte mask: only the residual bytes of len are valid; a full beat when len is aligned.
  function automatic logic [BYTES-1:0] keep_mask(input logic last, input logic [LW-1:0] l);
    logic [LW-1:0] rem;
    rem = l % LW'(BYTES);
    for (int i = 0; i < BYTES; i++) begin
      keep_mask[i] = !last || (rem == {LW{1'b0}}) || (LW'(i) < rem);
    end
  endfunction

  // Beat count, next beat index and the first word with same-cycle write bypass.
  always_comb begin
    nb_wide_s    = ({1'b0, len} + (LW+1)'(BYTES - 1)) / (LW+1)'(BYTES);
    nbeats_s     = (AW+1)'(nb_wide_s);
    beat_next_s  = beat_r + (AW+1)'(1);
    if (wr_en && (wr_addr == {AW{1'b0}})) begin
      first_word_s = wr_data;
    end else begin
      first_word_s = mem_r[0];
    end
  end

  // Staging memory: writable only while idle, never reset.
  always_ff @(posedge aclk) begin
    if ((state_r == S_IDLE) && wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Control FSM with registered stream and status outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      t_valid  <= 1'b0;
      t_last   <= 1'b0;
      t_data   <= {DATA_WIDTH{1'b0}};
      t_strb   <= {BYTES{1'b0}};
      t_keep   <= {BYTES{1'b0}};
      t_id     <= {ID_WIDTH{1'b0}};
      t_dest   <= {DEST_WIDTH{1'b0}};
      t_user   <= {USER_WIDTH{1'b0}};
      len_r    <= {LW{1'b0}};
      nbeats_r <= {(AW+1){1'b0}};
      beat_r   <= {(AW+1){1'b0}};
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            if (len == {LW{1'b0}}) begin
              done <= 1'b1;
            end else if (len > MAX_LEN) begin
              err <= 1'b1;
            end else begin
              state_r  <= S_SEND;
              busy     <= 1'b1;
              len_r    <= len;
              nbeats_r <= nbeats_s;
              beat_r   <= {(AW+1){1'b0}};
              t_valid  <= 1'b1;
              t_data   <= first_word_s;
              t_last   <= (nbeats_s == (AW+1)'(1));
              t_keep   <= keep_mask(nbeats_s == (AW+1)'(1), len);
              t_strb   <= keep_mask(nbeats_s == (AW+1)'(1), len);
              t_id     <= pkt_id;
              t_dest   <= pkt_dest;
              t_user   <= pkt_user;
            end
          end
        end
        S_SEND: begin
          err <= wr_en || start;
          if (t_valid && t_ready) begin
            if (t_last) begin
              state_r <= S_DONE;
              done    <= 1'b1;
              t_valid <= 1'b0;
              t_last  <= 1'b0;
            end else begin
              beat_r <= beat_next_s;
              t_data <= mem_r[beat_next_s[AW-1:0]];
              t_last <= (beat_next_s == nbeats_r - (AW+1)'(1));
              t_keep <= keep_mask(beat_next_s == nbeats_r - (AW+1)'(1), len_r);
              t_strb <= keep_mask(beat_next_s == nbeats_r - (AW+1)'(1), len_r);
            end
          end
        end
        S_DONE: begin
          err     <= wr_en || start;
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          t_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nasti_stream_tx.sv
// Self-checking bench for nasti_stream_tx: scenario tasks plus randomized packets checked
// against a byte-length model of the expected beat sequence.
module tb_nasti_stream_tx;

  localparam int DW = 64;
  localparam int BY = 8;
  localparam int BS = 8;
  localparam int AW = 3;
  localparam int LW = 7;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [LW-1:0] len;
  logic          pkt_id, pkt_dest, pkt_user;
  logic          busy, done, err;
  logic          t_valid, t_ready, t_last;
  logic [DW-1:0] t_data;
  logic [BY-1:0] t_strb, t_keep;
  logic          t_id, t_dest, t_user;

  logic [DW-1:0] model_mem [BS];
  int checks = 0;
  int errors = 0;

  nasti_stream_tx #(.ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1), .DATA_WIDTH(DW), .BUF_SIZE(BS)) dut (
    .aclk(aclk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .pkt_id(pkt_id), .pkt_dest(pkt_dest), .pkt_user(pkt_user),
    .busy(busy), .done(done), .err(err), .t_valid(t_valid), .t_ready(t_ready),
    .t_data(t_data), .t_strb(t_strb), .t_keep(t_keep), .t_last(t_last),
    .t_id(t_id), .t_dest(t_dest), .t_user(t_user)
  );

  always #5 aclk = ~aclk;

  task automatic write_word(input int a, input logic [DW-1:0] d);
    @(negedge aclk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    model_mem[a] = d;
    @(negedge aclk);
    wr_en = 1'b0;
  endtask

  // mode 0: ready always high, 1: toggling, 2: random. inject: wr_en/start while busy.
  // same_wr: write word 0 in the same cycle as start.
  task automatic run_packet(input string name, input int l, input int mode, input bit inject,
                            input bit same_wr);
    int n, idx, cyc, rem;
    bit fin;
    logic id, de, us;
    logic [BY-1:0] ek;
    logic [DW-1:0] hold0;
    n = (l + BY - 1) / BY;
    rem = l % BY;
    id = 1'($urandom); de = 1'($urandom); us = 1'($urandom);
    @(negedge aclk);
    start = 1'b1; len = LW'(l); pkt_id = id; pkt_dest = de; pkt_user = us;
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = {$urandom, $urandom};
      model_mem[0] = wr_data;
    end
    hold0 = model_mem[0];
    @(negedge aclk);
    start = 1'b0; wr_en = 1'b0;
    idx = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      case (mode)
        0: t_ready = 1'b1;
        1: t_ready = (cyc % 2 == 0);
        default: t_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject) begin
        if (cyc == 1) begin
          wr_en = 1'b1; wr_addr = '0; wr_data = ~hold0;
        end else if (cyc == 2) begin
          wr_en = 1'b0;
          checks++;
          if (err !== 1'b1) begin
            errors++; $display("FAIL %s err_on_wr: got %b want 1", name, err);
          end
          start = 1'b1; len = LW'(8);
        end else if (cyc == 3) begin
          start = 1'b0; len = LW'(l);
          checks++;
          if (err !== 1'b1) begin
            errors++; $display("FAIL %s err_on_start: got %b want 1", name, err);
          end
        end
      end
      if (idx < n) begin
        ek = (idx == n - 1 && rem != 0) ? BY'((1 << rem) - 1) : {BY{1'b1}};
        checks++;
        if (t_valid !== 1'b1 || busy !== 1'b1 || t_data !== model_mem[idx] || t_keep !== ek ||
            t_strb !== ek || t_last !== (idx == n - 1) || t_id !== id || t_dest !== de ||
            t_user !== us || done !== 1'b0) begin
          errors++;
          $display("FAIL %s beat%0d: got v=%b busy=%b data=%h keep=%h strb=%h last=%b id/dest/user=%b%b%b done=%b want v=1 busy=1 data=%h keep=%h last=%b id/dest/user=%b%b%b done=0",
                   name, idx, t_valid, busy, t_data, t_keep, t_strb, t_last, t_id, t_dest, t_user,
                   done, model_mem[idx], ek, (idx == n - 1), id, de, us);
        end
        if (t_valid && t_ready) idx++;
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || t_valid !== 1'b0 || err !== 1'b0) begin
          errors++;
          $display("FAIL %s done_cycle: got done=%b busy=%b valid=%b err=%b want 1 1 0 0",
                   name, done, busy, t_valid, err);
        end
        fin = 1'b1;
      end
      if (!fin) begin
        cyc++;
        if (cyc > 200) begin
          errors++; $display("FAIL %s timeout: got %0d beats want %0d", name, idx, n);
          fin = 1'b1;
        end
        @(negedge aclk);
      end
    end
    @(negedge aclk);
    t_ready = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || t_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_idle: got done=%b busy=%b valid=%b want 0 0 0", name, done, busy, t_valid);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #1;
    checks++;
    if ({t_valid, t_last, busy, done, err} !== 5'b0 || t_data !== '0 || t_keep !== '0 ||
        t_strb !== '0 || {t_id, t_dest, t_user} !== 3'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b l=%b busy=%b done=%b err=%b data=%h keep=%h want all 0",
               t_valid, t_last, busy, done, err, t_data, t_keep);
    end
    @(negedge aclk); @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_basic();
    write_word(0, {8{8'h11}});
    write_word(1, {8{8'h22}});
    write_word(2, {8{8'h33}});
    run_packet("basic_len20", 20, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    write_word(0, {$urandom, $urandom});
    write_word(1, {$urandom, $urandom});
    run_packet("stall_len16", 16, 1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_and_over();
    @(negedge aclk);
    start = 1'b1; len = LW'(0);
    @(negedge aclk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || t_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL zero_len: got done=%b valid=%b busy=%b err=%b want 1 0 0 0", done, t_valid, busy, err);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0 || t_valid !== 1'b0) begin
      errors++; $display("FAIL zero_len_after: got done=%b valid=%b want 0 0", done, t_valid);
    end
    start = 1'b1; len = LW'(65);
    @(negedge aclk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || t_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL over_len: got err=%b busy=%b valid=%b done=%b want 1 0 0 0", err, busy, t_valid, done);
    end
    @(negedge aclk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL over_len_after: got err=%b busy=%b want 0 0", err, busy);
    end
  endtask

  task automatic test_busy_err();
    for (int i = 0; i < 4; i++) write_word(i, {$urandom, $urandom});
    run_packet("busy_inject", 32, 1, 1'b1, 1'b0);
    run_packet("busy_followup", 8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle();
    run_packet("same_cycle_wr", 8, 0, 1'b0, 1'b1);
  endtask

  task automatic test_full();
    for (int i = 0; i < BS; i++) write_word(i, {$urandom, $urandom});
    run_packet("full_len64", 64, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    @(negedge aclk);
    t_ready = 1'b0; start = 1'b1; len = LW'(64);
    @(negedge aclk);
    start = 1'b0;
    @(negedge aclk);
    checks++;
    if (t_valid !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: got valid=%b want 1", t_valid);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (t_valid !== 1'b0 || busy !== 1'b0 || t_last !== 1'b0) begin
      errors++; $display("FAIL reset_mid_async: got valid=%b busy=%b last=%b want 0 0 0", t_valid, busy, t_last);
    end
    @(negedge aclk);
    aresetn = 1'b1; t_ready = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      if (done !== 1'b0 || t_valid !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++; $display("FAIL reset_mid_no_done: got %0d active cycles want 0", seen_done);
    end
    write_word(0, {$urandom, $urandom});
    run_packet("after_reset_len8", 8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      write_word(int'($urandom_range(0, BS - 1)), {$urandom, $urandom});
      run_packet("random", int'($urandom_range(1, BS * BY)), 2, 1'b0, 1'b0);
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; len = '0;
    pkt_id = 1'b0; pkt_dest = 1'b0; pkt_user = 1'b0; t_ready = 1'b0;
    for (int i = 0; i < BS; i++) model_mem[i] = '0;
    test_reset();
    for (int i = 0; i < BS; i++) write_word(i, '0);
    test_basic();
    test_stall();
    test_zero_and_over();
    test_busy_err();
    test_same_cycle();
    test_full();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
